// File: rtl/reaction_pkg.sv
// reaction_pkg: shared state encoding, BCD digit type and LFSR constants
// for the multi-player reaction timer.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_GO,
    ST_DONE,
    ST_FAULT
  } rtState_t;

  typedef logic [3:0] bcdDigit_t;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting left with feedback into bit 0
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_timer_mp_bcd_chain_counter.sv
// bcd_chain_counter: DIGITS-wide rippling BCD up-counter with synchronous
// clear, count enable, and an all-nines flag that also stops counting.
module bcd_chain_counter
  import reaction_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   value,
  output logic                  sat
);

  bcdDigit_t digitQ [DIGITS];
  bcdDigit_t digitD [DIGITS];
  logic      allNine;
  logic      carry;

  // Saturation: every digit showing 9
  always_comb begin
    allNine = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digitQ[i] != 4'd9) allNine = 1'b0;
    end
  end

  // Ripple increment: a 9 rolls to 0 and passes the carry upward
  always_comb begin
    carry = en & ~allNine;
    for (int i = 0; i < DIGITS; i++) begin
      digitD[i] = digitQ[i];
      if (carry) begin
        if (digitQ[i] == 4'd9) begin
          digitD[i] = 4'd0;
        end else begin
          digitD[i] = digitQ[i] + 4'd1;
          carry     = 1'b0;
        end
      end
    end
  end

  // Digit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) digitQ[i] <= 4'd0;
    end else if (clr) begin
      for (int i = 0; i < DIGITS; i++) digitQ[i] <= 4'd0;
    end else begin
      for (int i = 0; i < DIGITS; i++) digitQ[i] <= digitD[i];
    end
  end

  // Pack digits, least significant digit in the low nibble
  always_comb begin
    value = '0;
    for (int i = 0; i < DIGITS; i++) value[4*i +: 4] = digitQ[i];
  end

  assign sat = allNine;

endmodule

// File: rtl/reaction_timer_mp.sv
// reaction_timer_mp: multi-player reaction timer. A start pulse arms a
// random delay; when it expires go lights and elapsed ticks count in BCD
// until the first player presses stop. Pressing before go is a false start.
// Build option: define REACTION_BEST_SCORE_EN to keep a best-time register;
// otherwise best_bcd reads all nines and clear_best is ignored.
//
// state    | meaning
// ST_IDLE  | after reset, waiting for start
// ST_ARMED | random delay running, go low, stop = false start
// ST_GO    | go high, elapsed time counting, stop ends the round
// ST_DONE  | round over (stop or saturation), results held
// ST_FAULT | false start recorded, results held
module reaction_timer_mp
  import reaction_pkg::*;
#(
  parameter  int NUM_PLAYERS = 2,
  parameter  int DIGITS      = 4,
  parameter  int TICK_DIV    = 50000,
  parameter  int MIN_DELAY   = 1000,
  parameter  int RAND_BITS   = 11,
  localparam int WIN_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_PLAYERS-1:0] stop,
  input  logic                   clear_best,
  output logic                   go,
  output logic [4*DIGITS-1:0]    time_bcd,
  output logic [4*DIGITS-1:0]    best_bcd,
  output logic [WIN_W-1:0]       winner,
  output logic                   fault,
  output logic                   timeout,
  output logic                   done,
  output logic                   busy
);

  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DLY_RAW = $clog2(MIN_DELAY + (1 << RAND_BITS));
  localparam int DLY_W   = (DLY_RAW < 1) ? 1 : DLY_RAW;
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  rtState_t          stateQ, stateD;
  logic [15:0]       lfsrQ;
  logic [DIV_W-1:0]  divCnt;
  logic [DLY_W-1:0]  delayCnt;
  logic              tick;
  logic              stopAny;
  logic [WIN_W-1:0]  stopIdx;
  logic              timeSat;
  logic              timeEn;
  logic              loadDelay;
  logic              enterGo;
  logic              enterDone;
  logic              enterFault;
  logic              setTimeout;

  assign tick    = (divCnt == DIV_W'(TICK_DIV - 1));
  assign stopAny = |stop;

  // Lowest-numbered pressed stop wins a tie
  always_comb begin
    stopIdx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (stop[i]) stopIdx = WIN_W'(i);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= ST_IDLE;
    else        stateQ <= stateD;
  end

  // Next state; start overrides everything, including a same-cycle stop
  always_comb begin
    stateD     = stateQ;
    loadDelay  = 1'b0;
    enterGo    = 1'b0;
    enterDone  = 1'b0;
    enterFault = 1'b0;
    setTimeout = 1'b0;
    if (start) begin
      stateD    = ST_ARMED;
      loadDelay = 1'b1;
    end else begin
      case (stateQ)
        ST_ARMED: begin
          if (stopAny) begin
            stateD     = ST_FAULT;
            enterFault = 1'b1;
          end else if ((delayCnt == '0) || (tick && (delayCnt == DLY_W'(1)))) begin
            stateD  = ST_GO;
            enterGo = 1'b1;
          end
        end
        ST_GO: begin
          if (timeSat) begin
            stateD     = ST_DONE;
            enterDone  = 1'b1;
            setTimeout = 1'b1;
          end else if (stopAny) begin
            stateD    = ST_DONE;
            enterDone = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running LFSR supplying the random part of the delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsrQ <= LFSR_SEED;
    else        lfsrQ <= lfsrNext(lfsrQ);
  end

  // Tick divider, realigned whenever ARMED or GO is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    divCnt <= '0;
    else if (loadDelay || enterGo) divCnt <= '0;
    else if (tick)                 divCnt <= '0;
    else                           divCnt <= divCnt + DIV_W'(1);
  end

  // Random delay down-counter, one step per tick while ARMED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delayCnt <= '0;
    end else if (loadDelay) begin
      delayCnt <= DLY_W'(MIN_DELAY) + DLY_W'(lfsrQ[RAND_BITS-1:0]);
    end else if ((stateQ == ST_ARMED) && tick && (delayCnt != '0)) begin
      delayCnt <= delayCnt - DLY_W'(1);
    end
  end

  // Elapsed time only advances on ticks where the round carries on in GO
  assign timeEn = (stateQ == ST_GO) && tick && (stateD == ST_GO);

  bcd_chain_counter #(
    .DIGITS (DIGITS)
  ) uTimeCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (loadDelay | enterGo),
    .en    (timeEn),
    .value (time_bcd),
    .sat   (timeSat)
  );

  // Round result flags; cleared by start, set on round end, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      fault   <= 1'b0;
      timeout <= 1'b0;
      winner  <= '0;
    end else begin
      done <= enterDone | enterFault;
      if (loadDelay) begin
        fault   <= 1'b0;
        timeout <= 1'b0;
        winner  <= '0;
      end else begin
        if (enterFault) begin
          fault  <= 1'b1;
          winner <= stopIdx;
        end
        if (enterDone) begin
          if (setTimeout) timeout <= 1'b1;
          else            winner  <= stopIdx;
        end
      end
    end
  end

  assign go   = (stateQ == ST_GO);
  assign busy = (stateQ == ST_ARMED) || (stateQ == ST_GO);

`ifdef REACTION_BEST_SCORE_EN
  logic [4*DIGITS-1:0] bestQ;

  // Best time: BCD compares like binary; clear wins over a same-edge update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              bestQ <= ALL_NINES;
    else if (clear_best)                                     bestQ <= ALL_NINES;
    else if (enterDone && !setTimeout && (time_bcd < bestQ)) bestQ <= time_bcd;
  end

  assign best_bcd = bestQ;
`else
  logic unusedClearBest;
  assign unusedClearBest = clear_best;
  assign best_bcd        = ALL_NINES;
`endif

endmodule

// File: tb/tb_reaction_timer_mp.sv
`timescale 1ns/1ps
// tb_reaction_timer_mp: scenario tasks against a behavioural round model.
module tb_reaction_timer_mp;

  localparam int NP = 2;
  localparam int DG = 2;
  localparam int TD = 4;
  localparam int MD = 3;
  localparam int RB = 2;
`ifdef REACTION_BEST_SCORE_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NP-1:0] stop = '0;
  logic          clear_best = 1'b0;
  logic          go, fault, timeout, done, busy;
  logic [4*DG-1:0] time_bcd, best_bcd;
  logic [0:0]    winner;

  int nChecks = 0;
  int nFails  = 0;
  int bestModel = 99;
  logic [15:0] mLfsr;

  always #5 clk = ~clk;

  reaction_timer_mp #(
    .NUM_PLAYERS (NP), .DIGITS (DG), .TICK_DIV (TD), .MIN_DELAY (MD), .RAND_BITS (RB)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .stop (stop), .clear_best (clear_best),
    .go (go), .time_bcd (time_bcd), .best_bcd (best_bcd), .winner (winner),
    .fault (fault), .timeout (timeout), .done (done), .busy (busy)
  );

  // Reference random source: x^16+x^14+x^13+x^11+1, seed ACE1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mLfsr <= 16'hACE1;
    else        mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
  end

  function automatic logic [7:0] toBcd(input int v);
    toBcd = 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // Round rules: delay = MD + rand ticks, go visible 4*delay+1 negedges after start;
  // a stop k cycles after go is first seen freezes time at k/4 ticks.
  task automatic startRound(output int d);
    d = MD + int'(mLfsr[RB-1:0]);
    start = 1'b1;
  endtask

  task automatic waitGo(output int n);
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      start = 1'b0;
      stop  = '0;
      n++;
      if (go) break;
    end
  endtask

  task automatic stopAfter(input int k, input logic [NP-1:0] s);
    repeat (k) @(negedge clk);
    stop = s;
    @(negedge clk);
    stop = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++; if (go !== 1'b0) begin nFails++; $display("FAIL reset go: got %b want 0", go); end
    nChecks++; if (time_bcd !== 8'h00) begin nFails++; $display("FAIL reset time: got %h want 00", time_bcd); end
    nChecks++; if (best_bcd !== 8'h99) begin nFails++; $display("FAIL reset best: got %h want 99", best_bcd); end
    nChecks++; if (winner !== 1'b0) begin nFails++; $display("FAIL reset winner: got %b want 0", winner); end
    nChecks++; if ({fault, timeout, done, busy} !== 4'b0000) begin nFails++; $display("FAIL reset flags: got %b want 0000", {fault, timeout, done, busy}); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_ignore;
    @(negedge clk);
    stop = 2'b01;
    @(negedge clk);
    stop = '0;
    nChecks++; if ({done, fault, busy, go, winner} !== 5'b0) begin nFails++; $display("FAIL idle stop: got %b want 00000", {done, fault, busy, go, winner}); end
  endtask

  task automatic test_first_round;
    int d, n, k, guard;
    guard = 0;
    while ((mLfsr[1:0] != 2'd2) && (guard < 200)) begin @(negedge clk); guard++; end
    startRound(d);
    waitGo(n);
    nChecks++; if (n != 4 * d + 1) begin nFails++; $display("FAIL first go delay: got %0d want %0d", n, 4 * d + 1); end
    k = 48 + $urandom_range(0, 3);
    stopAfter(k, 2'b10);
    if (BEST_EN && (12 < bestModel)) bestModel = 12;
    nChecks++; if (done !== 1'b1) begin nFails++; $display("FAIL first done: got %b want 1", done); end
    nChecks++; if (time_bcd !== 8'h12) begin nFails++; $display("FAIL first time: got %h want 12", time_bcd); end
    nChecks++; if (winner !== 1'b1) begin nFails++; $display("FAIL first winner: got %b want 1", winner); end
    nChecks++; if (best_bcd !== toBcd(bestModel)) begin nFails++; $display("FAIL first best: got %h want %h", best_bcd, toBcd(bestModel)); end
    nChecks++; if ({go, busy, fault, timeout} !== 4'b0) begin nFails++; $display("FAIL first flags: got %b want 0000", {go, busy, fault, timeout}); end
    @(negedge clk);
    nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL first done width: got %b want 0", done); end
    nChecks++; if (time_bcd !== 8'h12) begin nFails++; $display("FAIL first hold: got %h want 12", time_bcd); end
  endtask

  task automatic test_fault;
    logic [NP-1:0] pats [2];
    int d, j;
    logic sawGo;
    pats[0] = 2'b01;
    pats[1] = 2'b10;
    for (int p = 0; p < 2; p++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      startRound(d);
      j = $urandom_range(1, 4 * d);
      sawGo = 1'b0;
      repeat (j) begin @(negedge clk); start = 1'b0; if (go) sawGo = 1'b1; end
      stop = pats[p];
      @(negedge clk);
      stop = '0;
      nChecks++; if ({done, fault} !== 2'b11) begin nFails++; $display("FAIL fault entry %0d: got %b want 11", p, {done, fault}); end
      nChecks++; if (winner !== 1'(p)) begin nFails++; $display("FAIL fault winner %0d: got %b want %0d", p, winner, p); end
      nChecks++; if (best_bcd !== toBcd(bestModel)) begin nFails++; $display("FAIL fault best: got %h want %h", best_bcd, toBcd(bestModel)); end
      nChecks++; if (time_bcd !== 8'h00) begin nFails++; $display("FAIL fault time: got %h want 00", time_bcd); end
      repeat (4 * d + 8) begin @(negedge clk); if (go || done || busy) sawGo = 1'b1; end
      nChecks++; if (sawGo !== 1'b0) begin nFails++; $display("FAIL fault go or done seen: got %b want 0", sawGo); end
      nChecks++; if (fault !== 1'b1) begin nFails++; $display("FAIL fault hold: got %b want 1", fault); end
    end
  endtask

  task automatic test_tie_and_priority;
    int d, n, k;
    startRound(d);
    waitGo(n);
    nChecks++; if (n != 4 * d + 1) begin nFails++; $display("FAIL tie go delay: got %0d want %0d", n, 4 * d + 1); end
    k = $urandom_range(0, 40);
    stopAfter(k, 2'b11);
    if (BEST_EN && (k / 4 < bestModel)) bestModel = k / 4;
    nChecks++; if (winner !== 1'b0) begin nFails++; $display("FAIL tie winner: got %b want 0", winner); end
    nChecks++; if (time_bcd !== toBcd(k / 4)) begin nFails++; $display("FAIL tie time: got %h want %h", time_bcd, toBcd(k / 4)); end
    @(negedge clk);
    startRound(d);
    waitGo(n);
    stopAfter($urandom_range(0, 20), 2'b10);
    nChecks++; if (winner !== 1'b1) begin nFails++; $display("FAIL pre-restart winner: got %b want 1", winner); end
    @(negedge clk);
    startRound(d);
    waitGo(n);
    repeat ($urandom_range(4, 20)) @(negedge clk);
    startRound(d);
    stop = 2'b01;
    @(negedge clk);
    start = 1'b0;
    stop  = '0;
    nChecks++; if ({done, go, busy} !== 3'b001) begin nFails++; $display("FAIL restart flags: got %b want 001", {done, go, busy}); end
    nChecks++; if ({time_bcd, winner} !== 9'd0) begin nFails++; $display("FAIL restart cleared: got %h want 000", {time_bcd, winner}); end
    waitGo(n);
    nChecks++; if (n + 1 != 4 * d + 1) begin nFails++; $display("FAIL restart go delay: got %0d want %0d", n + 1, 4 * d + 1); end
    stopAfter(8, 2'b01);
    if (BEST_EN && (2 < bestModel)) bestModel = 2;
    nChecks++; if ({done, time_bcd} !== {1'b1, 8'h02}) begin nFails++; $display("FAIL restart end: got %h want 102", {done, time_bcd}); end
  endtask

  task automatic test_random_rounds;
    int d, n, k;
    logic [NP-1:0] s;
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      startRound(d);
      waitGo(n);
      nChecks++; if (n != 4 * d + 1) begin nFails++; $display("FAIL rnd%0d go delay: got %0d want %0d", r, n, 4 * d + 1); end
      k = $urandom_range(0, 120);
      s = NP'($urandom_range(1, 3));
      stopAfter(k, s);
      if (BEST_EN && (k / 4 < bestModel)) bestModel = k / 4;
      nChecks++; if (time_bcd !== toBcd(k / 4)) begin nFails++; $display("FAIL rnd%0d time: got %h want %h", r, time_bcd, toBcd(k / 4)); end
      nChecks++; if (winner !== (s[0] ? 1'b0 : 1'b1)) begin nFails++; $display("FAIL rnd%0d winner: got %b want %b", r, winner, ~s[0]); end
      nChecks++; if ({done, go, fault, timeout} !== 4'b1000) begin nFails++; $display("FAIL rnd%0d flags: got %b want 1000", r, {done, go, fault, timeout}); end
      nChecks++; if (best_bcd !== toBcd(bestModel)) begin nFails++; $display("FAIL rnd%0d best: got %h want %h", r, best_bcd, toBcd(bestModel)); end
      @(negedge clk);
      nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL rnd%0d done width: got %b want 0", r, done); end
    end
  endtask

  task automatic test_timeout;
    int d, n, k;
    startRound(d);
    waitGo(n);
    k = 0;
    while (!done && (k < 1000)) begin @(negedge clk); k++; end
    nChecks++; if (k != 397) begin nFails++; $display("FAIL timeout cycles: got %0d want 397", k); end
    nChecks++; if (time_bcd !== 8'h99) begin nFails++; $display("FAIL timeout time: got %h want 99", time_bcd); end
    nChecks++; if ({timeout, go, fault, winner} !== 4'b1000) begin nFails++; $display("FAIL timeout flags: got %b want 1000", {timeout, go, fault, winner}); end
    nChecks++; if (best_bcd !== toBcd(bestModel)) begin nFails++; $display("FAIL timeout best: got %h want %h", best_bcd, toBcd(bestModel)); end
    stop = 2'b10;
    @(negedge clk);
    stop = '0;
    @(negedge clk);
    nChecks++; if ({done, winner, timeout, time_bcd} !== {1'b0, 1'b0, 1'b1, 8'h99}) begin nFails++; $display("FAIL done ignores stop: got %h want 199", {done, winner, timeout, time_bcd}); end
  endtask

  task automatic test_clear_best;
    int d, n, k;
    clear_best = 1'b1;
    @(negedge clk);
    clear_best = 1'b0;
    bestModel = 99;
    nChecks++; if (best_bcd !== 8'h99) begin nFails++; $display("FAIL clear best: got %h want 99", best_bcd); end
    startRound(d);
    waitGo(n);
    k = $urandom_range(4, 40);
    repeat (k) @(negedge clk);
    stop = 2'b01;
    clear_best = 1'b1;
    @(negedge clk);
    stop = '0;
    clear_best = 1'b0;
    nChecks++; if ({done, time_bcd} !== {1'b1, toBcd(k / 4)}) begin nFails++; $display("FAIL clear race round: got %h want 1%h", {done, time_bcd}, toBcd(k / 4)); end
    nChecks++; if (best_bcd !== 8'h99) begin nFails++; $display("FAIL clear priority: got %h want 99", best_bcd); end
    startRound(d);
    waitGo(n);
    k = $urandom_range(4, 60);
    stopAfter(k, 2'b10);
    if (BEST_EN && (k / 4 < bestModel)) bestModel = k / 4;
    nChecks++; if (best_bcd !== toBcd(bestModel)) begin nFails++; $display("FAIL best after clear: got %h want %h", best_bcd, toBcd(bestModel)); end
  endtask

  task automatic test_reset_mid_go;
    int d, n;
    logic sawAct;
    startRound(d);
    waitGo(n);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    bestModel = 99;
    nChecks++; if ({go, busy, done, fault, timeout, winner} !== 6'b0) begin nFails++; $display("FAIL async reset flags: got %b want 000000", {go, busy, done, fault, timeout, winner}); end
    nChecks++; if ({time_bcd, best_bcd} !== 16'h0099) begin nFails++; $display("FAIL async reset values: got %h want 0099", {time_bcd, best_bcd}); end
    @(negedge clk);
    rst_n = 1'b1;
    sawAct = 1'b0;
    repeat (6) begin @(negedge clk); if (done || busy || go) sawAct = 1'b1; end
    nChecks++; if (sawAct !== 1'b0) begin nFails++; $display("FAIL post-reset activity: got %b want 0", sawAct); end
    startRound(d);
    waitGo(n);
    nChecks++; if (n != 4 * d + 1) begin nFails++; $display("FAIL reseed go delay: got %0d want %0d", n, 4 * d + 1); end
    stopAfter(4, 2'b01);
    nChecks++; if ({done, time_bcd} !== {1'b1, 8'h01}) begin nFails++; $display("FAIL reseed round: got %h want 101", {done, time_bcd}); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_first_round();
    test_fault();
    test_tie_and_priority();
    test_random_rounds();
    test_timeout();
    test_clear_best();
    test_reset_mid_go();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
